// File: rtl/tw_table_writer.sv
// Twiddle-table writer: streams seed*w^k mod q for k = 0..2^STAGE-1 over a
// we/waddr/wdata port with wready back-pressure, using a bit-serial modular multiplier.
module tw_table_writer #(
  parameter int unsigned LOGQ  = 12,
  parameter int unsigned LOGN  = 12,
  parameter int unsigned STAGE = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            intt_i,
  input  logic [LOGQ-1:0] q_i,
  input  logic [LOGQ-1:0] w_i,
  input  logic [LOGQ-1:0] seed_i,
  input  logic            wready_i,
  output logic            we_o,
  output logic [LOGN-1:0] waddr_o,
  output logic [LOGQ-1:0] wdata_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int unsigned DEPTH = 2 ** STAGE;
  localparam int unsigned KW    = STAGE;
  localparam int unsigned AW    = LOGQ + 2;
  localparam int unsigned IW    = (LOGQ > 1) ? $clog2(LOGQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_MUL   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [LOGQ-1:0] q_q, q_d, w_q, w_d, seed_q, seed_d;
  logic            intt_q, intt_d;
  logic [KW-1:0]   k_q, k_d;
  logic [LOGQ-1:0] cur_q, cur_d, acc_q, acc_d;
  logic [IW-1:0]   i_q, i_d;
  logic            we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [LOGN-1:0] waddr_q, waddr_d;
  logic [LOGQ-1:0] wdata_q, wdata_d;

  logic [AW-1:0]   mul_t, mul_s1, mul_s2;
  logic [LOGQ-1:0] mul_acc;

  // Inverse tables negate every entry except those equal to the seed.
  function automatic logic [LOGQ-1:0] table_val(input logic [LOGQ-1:0] cur,
                                                input logic [LOGQ-1:0] seed,
                                                input logic [LOGQ-1:0] q,
                                                input logic            neg);
    if (neg && (cur != seed)) return q - cur;
    return cur;
  endfunction

  // One step of the MSB-first interleaved multiply; t < 3q so two subtractions suffice.
  assign mul_t   = (AW'(acc_q) << 1) + (w_q[i_q] ? AW'(cur_q) : '0);
  assign mul_s1  = (mul_t >= AW'(q_q)) ? (mul_t - AW'(q_q)) : mul_t;
  assign mul_s2  = (mul_s1 >= AW'(q_q)) ? (mul_s1 - AW'(q_q)) : mul_s1;
  assign mul_acc = LOGQ'(mul_s2);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    w_d     = w_q;
    seed_d  = seed_q;
    intt_d  = intt_q;
    k_d     = k_q;
    cur_d   = cur_q;
    acc_d   = acc_q;
    i_d     = i_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        we_d   = 1'b0;
        busy_d = 1'b0;
        if (start_i) begin
          q_d     = q_i;
          w_d     = w_i;
          seed_d  = seed_i;
          intt_d  = intt_i;
          k_d     = '0;
          cur_d   = seed_i;
          we_d    = 1'b1;
          waddr_d = '0;
          wdata_d = seed_i;
          busy_d  = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wready_i) begin
          we_d = 1'b0;
          if (k_q == KW'(DEPTH - 1)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            k_d     = k_q + KW'(1);
            acc_d   = '0;
            i_d     = IW'(LOGQ - 1);
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        i_d   = i_q - IW'(1);
        if (i_q == '0) begin
          cur_d   = mul_acc;
          we_d    = 1'b1;
          waddr_d = LOGN'(k_q);
          wdata_d = table_val(mul_acc, seed_q, q_q, intt_q);
          state_d = S_WRITE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      w_q     <= '0;
      seed_q  <= '0;
      intt_q  <= 1'b0;
      k_q     <= '0;
      cur_q   <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      w_q     <= w_d;
      seed_q  <= seed_d;
      intt_q  <= intt_d;
      k_q     <= k_d;
      cur_q   <= cur_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: doc/tw_table_writer.md
# tw_table_writer

Sequential twiddle-table generator for the SDF NTT pipeline: the write side of a per-stage twiddle memory. On `start` it computes `seed·w^k mod q` for k = 0 … 2^STAGE−1 using an internal bit-serial modular multiplier and streams each value, in order, over a `we`/`waddr`/`wdata` port with `wready` back-pressure. It replaces a fixed ROM when q or ω is chosen at run time. In `intt` mode it writes the negated table (`q − v`, except entries equal to `seed`), matching the inverse-NTT convention of the read side.

## Interface
- `LOGQ`, 12, width of q and of all coefficient values
- `LOGN`, 12, width of `waddr`
- `STAGE`, 3, table depth is `DEPTH = 2^STAGE`; requires 1 ≤ STAGE ≤ LOGN

- `clk` in 1, single clock, rising edge
- `rst` in 1, synchronous, active-high reset
- `start` in 1, begin generation; sampled only in IDLE
- `intt` in 1, captured at start; selects the negated table
- `q` in LOGQ, modulus; captured at start; requires q ≥ 2
- `w` in LOGQ, root ω; captured at start; requires w < q
- `seed` in LOGQ, entry 0 value (1, or R for Montgomery domain); captured at start; requires seed < q
- `wready` in 1, sink accepts the write this cycle
- `we` out 1, write valid
- `waddr` out LOGN, entry index k, zero-extended
- `wdata` out LOGQ, entry value
- `busy` out 1, high in WRITE, MUL and DONE
- `done` out 1, one-cycle completion pulse

## Operation
- FSM states: IDLE, WRITE, MUL, DONE.
- IDLE:
  - On `start`, register q, w, seed and intt; set k = 0 and cur = seed; go to WRITE.
  - `start` is ignored in every other state.
- WRITE:
  - `we = 1`, `waddr = k`.
  - `wdata = cur` when `intt = 0`; when `intt = 1`, `wdata = (cur == seed) ? cur : q − cur`.
  - If `wready = 0`, hold all outputs and state unchanged.
  - If `wready = 1` and k = DEPTH−1, go to DONE.
  - Otherwise increment k, clear the accumulator, set bit index i = LOGQ−1, and go to MUL.
- MUL (interleaved modular multiply, exactly LOGQ cycles):
  - Each cycle: `t = 2·acc + (w[i] ? cur : 0)`, so t < 3q.
  - Then `acc = t mod q`, done with at most two conditional subtractions of q; decrement i.
  - After the i = 0 cycle, `cur = acc = cur·w mod q`; go to WRITE.
  - Internal arithmetic is LOGQ+2 bits wide; there is no truncation.
- DONE: `done = 1` for one cycle, then go to IDLE.
- `rst` in any state:
  - Next cycle is IDLE with all outputs 0 and internal registers cleared.
  - Any partial table is abandoned and no further write is issued.
- Out-of-range inputs (w ≥ q, seed ≥ q, q < 2) give undefined data but the same handshake and timing.

## Timing
- Reset values: `we = 0`, `waddr = 0`, `wdata = 0`, `busy = 0`, `done = 0`.
- All outputs are registered. `we`, `waddr` and `wdata` are stable while `we = 1` and `wready = 0`.
- With `wready` held at 1 and `start` seen at cycle 0:
  - Write k is presented at cycle 1 + k·(LOGQ+1).
  - The last write is at cycle 1 + (DEPTH−1)·(LOGQ+1).
  - `done` is high the following cycle, and `start` is accepted again the cycle after that.
- Each cycle `wready` is low at a WRITE adds exactly one cycle of delay; MUL is never stalled.
- `busy` rises in cycle 1 and falls in the cycle after `done`.

## Test plan
- Forward table:
  - Setup: LOGQ = 12, STAGE = 3, q = 3329, w = 17, seed = 1, intt = 0, `wready` = 1.
  - Required: writes (0:1), (1:17), (2:289), (3:1584), (4:296), (5:1703), (6:2319), (7:2804) at cycles 1, 14, 27, …, 92; `done` at cycle 93.
- Inverse table:
  - Same setup with intt = 1.
  - Required data: 1, 3312, 3040, 1745, 3033, 1626, 1010, 525, at identical timing.
- Back-pressure:
  - Same as the forward case, with `wready` = 0 for 3 cycles at k = 2 and for 1 cycle at k = 7.
  - Required: identical address/data sequence, outputs held during stalls, `done` at cycle 97, and exactly 8 accepted writes.
- Reset mid-operation:
  - Assert `rst` for 1 cycle during MUL after write k = 3.
  - Required: all outputs 0 the next cycle, no further writes, and a fresh `start` reproduces the forward table from k = 0.
- Start while busy plus Montgomery seed:
  - Pulse `start` during MUL; it must be ignored.
  - Then run seed = 4096 mod 3329 = 767, w = 17, intt = 0.
  - Required: entry k = 767·17^k mod 3329, i.e. 767, 3052, 1949, …
- Degenerate root:
  - Setup: w = 1, seed = 5, intt = 1.
  - Required: all 8 entries equal 5, because the `cur == seed` exemption applies to every entry.
